// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: data-size codes,
// EX/MEM and MEM/WB bundle field offsets/widths, and the FSM state type.
package mem_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DSZ_WORD  = 2'b00,
        DSZ_HALF  = 2'b01,
        DSZ_BYTE  = 2'b10,
        DSZ_WORD2 = 2'b11
    } dsize_t;

    // EX/MEM bundle, bit 0 is the MSB of nextPC
    localparam int EXM_W        = 174;
    localparam int EXM_NPC      = 0;
    localparam int EXM_OPB      = 32;
    localparam int EXM_DEST     = 64;
    localparam int EXM_ALU      = 69;
    localparam int EXM_PC2REG   = 101;
    localparam int EXM_REG2PC   = 102;
    localparam int EXM_REGWR    = 103;
    localparam int EXM_MEM2REG  = 104;
    localparam int EXM_MEMWR    = 105;
    localparam int EXM_LDSIGN   = 106;
    localparam int EXM_DSIZE    = 107;
    localparam int EXM_LEAPADDR = 109;
    localparam int EXM_LEAP     = 141;
    localparam int EXM_MEMVAL   = 142;

    // MEM/WB bundle
    localparam int MWB_W      = 104;
    localparam int MWB_NPC    = 0;
    localparam int MWB_DEST   = 32;
    localparam int MWB_ALU    = 37;
    localparam int MWB_LDATA  = 69;
    localparam int MWB_PC2REG = 101;
    localparam int MWB_REGWR  = 102;
    localparam int MWB_MEM2REG = 103;

    localparam int DEST_W = 5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between the memory stage (master) and the memory (slave).
// req/we/addr/wdata/be go out; rdata/ack come back, ack may be same-cycle.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            req;
    logic            we;
    logic [0:XLEN-1] addr;
    logic [0:XLEN-1] wdata;
    logic [0:3]      be;
    logic [0:XLEN-1] rdata;
    logic            ack;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack
    );

endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store data replication and byte enables,
// load byte/half extraction with sign/zero extension, misalign detection.
// Ports: dsize/off/load_sign/is_store/mem_val/rdata in; wdata/be/load_data/misalign out.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]      dsize,
    input  logic [1:0]      off,
    input  logic            load_sign,
    input  logic            is_store,
    input  logic [0:XLEN-1] mem_val,
    input  logic [0:XLEN-1] rdata,
    output logic [0:XLEN-1] wdata,
    output logic [0:3]      be,
    output logic [0:XLEN-1] load_data,
    output logic            misalign
);

    logic [0:7]  byte_v;
    logic [0:15] half_v;
    logic [0:3]  st_be;

    always_comb begin
        byte_v    = rdata[0:7];
        half_v    = rdata[0:15];
        wdata     = mem_val;
        st_be     = 4'b1111;
        load_data = rdata;
        misalign  = 1'b0;

        unique case (off)
            2'd0:    byte_v = rdata[0:7];
            2'd1:    byte_v = rdata[8:15];
            2'd2:    byte_v = rdata[16:23];
            default: byte_v = rdata[24:31];
        endcase
        half_v = off[1] ? rdata[16:31] : rdata[0:15];

        unique case (dsize)
            DSZ_BYTE: begin
                wdata     = {4{mem_val[24:31]}};
                // be[0] is the leftmost bit, so shifting right selects lane `off`
                st_be     = 4'b1000 >> off;
                load_data = {{24{load_sign & byte_v[0]}}, byte_v};
            end
            DSZ_HALF: begin
                wdata     = {2{mem_val[16:31]}};
                st_be     = off[1] ? 4'b0011 : 4'b1100;
                load_data = {{16{load_sign & half_v[0]}}, half_v};
                misalign  = off[0];
            end
            default: begin
                misalign = (off != 2'd0);
            end
        endcase

        be = is_store ? st_be : 4'b1111;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory requests, stalls upstream while
// waiting for ack, aborts on timeout, and holds the MEM/WB register.
// Ports: clk, reset (async low), in (EX/MEM), out (MEM/WB), stall,
// dmem (memory master port), misalign pulse, bus_err sticky flag.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int IN_W    = 174,
    parameter int OUT_W   = 104,
    parameter int TIMEOUT = 16
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [0:IN_W-1]  in,
    output logic [0:OUT_W-1] out,
    output logic             stall,
    mem_stage_if.master      dmem,
    output logic             misalign,
    output logic             bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // cnt_q counts finished WAIT cycles; the abort cycle is request
    // cycle number TIMEOUT, i.e. the WAIT cycle that sees TIMEOUT-2.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    logic [0:XLEN-1]   npc;
    logic [0:XLEN-1]   alu;
    logic [0:XLEN-1]   mem_val;
    logic [0:DEST_W-1] dest;
    logic              pc2reg;
    logic              reg_wr;
    logic              mem2reg;
    logic              mem_wr;
    logic              ld_sign;
    logic [1:0]        dsize;

    assign npc     = in[EXM_NPC +: XLEN];
    assign alu     = in[EXM_ALU +: XLEN];
    assign mem_val = in[EXM_MEMVAL +: XLEN];
    assign dest    = in[EXM_DEST +: DEST_W];
    assign pc2reg  = in[EXM_PC2REG];
    assign reg_wr  = in[EXM_REGWR];
    assign mem2reg = in[EXM_MEM2REG];
    assign mem_wr  = in[EXM_MEMWR];
    assign ld_sign = in[EXM_LDSIGN];
    assign dsize   = in[EXM_DSIZE +: 2];

    logic unused_in;
    assign unused_in = ^{in[EXM_OPB +: XLEN], in[EXM_REG2PC],
                         in[EXM_LEAPADDR +: XLEN + 1]};

    logic [0:XLEN-1] st_wdata;
    logic [0:3]      st_be;
    logic [0:XLEN-1] ld_data;
    logic            mis;

    mem_align u_align (
        .dsize     (dsize),
        .off       (alu[30:31]),
        .load_sign (ld_sign),
        .is_store  (mem_wr),
        .mem_val   (mem_val),
        .rdata     (dmem.rdata),
        .wdata     (st_wdata),
        .be        (st_be),
        .load_data (ld_data),
        .misalign  (mis)
    );

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic [0:OUT_W-1] out_q, out_d;

    logic            memop;
    logic            go;
    logic            abort;
    logic [0:XLEN-1] load_out;
    logic            wr_out;
    logic            m2r_out;

    always_comb begin
        memop = mem2reg | mem_wr;
        go    = memop & ~mis;
        abort = (state_q == S_WAIT) & ~dmem.ack & (cnt_q == CNT_LAST);
    end

    // Outputs are forced low while reset is held, even mid-transaction.
    always_comb begin
        dmem.req   = reset & go & ~abort;
        dmem.we    = reset & go & mem_wr;
        dmem.addr  = {alu[0:29], 2'b00};
        dmem.wdata = st_wdata;
        dmem.be    = st_be;
        stall      = reset & go & ~dmem.ack & ~abort;
        misalign   = reset & memop & mis;
        bus_err    = bus_err_q;
        out        = out_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q | abort;
        unique case (state_q)
            S_IDLE: begin
                if (go & ~dmem.ack) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (dmem.ack | abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A stalled edge writes a bubble so writeback never sees a duplicate.
    always_comb begin
        load_out = (mem2reg & go & dmem.ack) ? ld_data : '0;
        wr_out   = reg_wr & ~(memop & mis) & ~abort;
        m2r_out  = mem2reg & ~mis;
        out_d    = stall ? '0 : {npc, dest, alu, load_out,
                                 pc2reg, wr_out, m2r_out};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            out_q     <= out_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized
// loads/stores/ALU ops checked against a behavioural model.
module tb_mem_stage;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 99;

    logic         clk = 1'b0;
    logic         reset;
    logic [0:173] in_b;
    logic [0:103] out_b;
    logic         stall;
    logic         misalign;
    logic         bus_err;

    mem_stage_if dmem_if ();

    mem_stage #(
        .IN_W    (174),
        .OUT_W   (104),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_b),
        .out      (out_b),
        .stall    (stall),
        .dmem     (dmem_if),
        .misalign (misalign),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic exp_bus_err = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:173] mk(
        input logic [31:0] npc, input logic [31:0] alu,
        input logic [31:0] mval, input logic [4:0] dest,
        input logic pc2reg, input logic rw, input logic m2r,
        input logic mw, input logic sgn, input logic [1:0] dsz);
        logic [31:0] opb;
        logic [31:0] la;
        logic        r2pc;
        logic        leap;
        opb  = $urandom();
        la   = $urandom();
        r2pc = 1'($urandom());
        leap = 1'($urandom());
        mk = {npc, opb, dest, alu, pc2reg, r2pc, rw, m2r, mw, sgn,
              dsz, la, leap, mval};
    endfunction

    // lat = number of cycles after the request cycle before ack arrives
    task automatic run_op(
        input logic [31:0] alu, input logic [31:0] mval,
        input logic rw, input logic m2r, input logic mw,
        input logic sgn, input logic [1:0] dsz,
        input int lat, input logic [31:0] rd);
        logic [0:173] bundle;
        logic [31:0]  npc;
        logic [4:0]   dest;
        logic         pc2reg;
        int           sz;
        int           o;
        logic         memop;
        logic         mis;
        logic         go;
        logic         aborted;
        int           nst;
        logic [0:3]   be_e;
        logic [31:0]  wd_e;
        logic [31:0]  v;
        logic [31:0]  mask;
        logic         req_e;

        npc    = $urandom();
        dest   = 5'($urandom());
        pc2reg = 1'($urandom());
        bundle = mk(npc, alu, mval, dest, pc2reg, rw, m2r, mw, sgn, dsz);

        sz      = (dsz == 2'b01) ? 2 : (dsz == 2'b10) ? 1 : 4;
        o       = int'(alu[1:0]);
        memop   = m2r | mw;
        mis     = (o % sz) != 0;
        go      = memop && !mis;
        aborted = go && (lat >= TIMEOUT);
        nst     = !go ? 0 : (lat < TIMEOUT - 1) ? lat : TIMEOUT - 1;

        for (int k = 0; k < 4; k++)
            be_e[k] = mw ? (k >= o && k < o + sz) : 1'b1;
        if (sz == 4)      wd_e = mval;
        else if (sz == 2) wd_e = (mval & 32'hFFFF) * 32'h0001_0001;
        else              wd_e = (mval & 32'hFF) * 32'h0101_0101;

        if (sz == 4) begin
            v = rd;
        end else begin
            mask = (32'd1 << (8 * sz)) - 32'd1;
            v = (rd >> (8 * (4 - o - sz))) & mask;
            if (sgn && v[8 * sz - 1]) v = v | ~mask;
        end

        for (int c = 0; c <= nst; c++) begin
            @(negedge clk);
            in_b          = bundle;
            dmem_if.ack   = go && (c == lat);
            dmem_if.rdata = dmem_if.ack ? rd : $urandom();
            #1;
            req_e = go && !(aborted && c == nst);
            chk("req", dmem_if.req, req_e);
            chk("stall", stall, c < nst);
            chk("misalign", misalign, memop && mis);
            if (req_e) begin
                chk("addr", dmem_if.addr, alu & 32'hFFFF_FFFC);
                chk("we", dmem_if.we, mw);
                chk("be", dmem_if.be, be_e);
                if (mw) chk("wdata", dmem_if.wdata, wd_e);
            end
            @(posedge clk);
            #1;
            if (c < nst) chk("bubble", out_b, 0);
        end
        dmem_if.ack = 1'b0;

        exp_bus_err = exp_bus_err | aborted;
        chk("out.nextPC", out_b[0:31], npc);
        chk("out.destReg", out_b[32:36], dest);
        chk("out.aluResult", out_b[37:68], alu);
        chk("out.PCtoReg", out_b[101], pc2reg);
        chk("out.RegWrite", out_b[102], rw && !(memop && mis) && !aborted);
        chk("out.MemToReg", out_b[103], m2r && !mis);
        if (!(memop && mis) && !aborted)
            chk("out.loadData", out_b[69:100], m2r ? v : 32'd0);
        chk("bus_err", bus_err, exp_bus_err);
    endtask

    initial begin
        int          kind;
        int          lat;
        logic [31:0] a;
        logic [1:0]  dsz;

        reset         = 1'b0;
        dmem_if.ack   = 1'b0;
        dmem_if.rdata = '0;
        in_b = mk(32'h0, 32'h100, 32'h0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0,
                  1'b0, 2'b00);
        #1;
        chk("rst req", dmem_if.req, 0);
        chk("rst stall", stall, 0);
        in_b = mk(32'h0, 32'h101, 32'h0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0,
                  1'b0, 2'b00);
        #1;
        chk("rst misalign", misalign, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst out", out_b, 0);
        chk("rst bus_err", bus_err, 0);
        @(negedge clk);
        in_b  = mk(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 2'b00);
        reset = 1'b1;

        // LW, same-cycle ack
        run_op(32'h100, 32'h0, 1, 1, 0, 0, 2'b00, 0, 32'hDEAD_BEEF);
        // LB signed / unsigned at 0x103, ack after 3 cycles
        run_op(32'h103, 32'h0, 1, 1, 0, 1, 2'b10, 3, 32'h0000_00F0);
        run_op(32'h103, 32'h0, 1, 1, 0, 0, 2'b10, 3, 32'h0000_00F0);
        // SH at 0x202
        run_op(32'h202, 32'h1234_ABCD, 0, 0, 1, 0, 2'b01, 0, 32'h0);
        // Misaligned LW
        run_op(32'h101, 32'h0, 1, 1, 0, 0, 2'b00, 0, 32'h1111_2222);
        // Ack exactly in the timeout cycle wins
        run_op(32'h104, 32'h0, 1, 1, 0, 0, 2'b00, TIMEOUT - 1,
               32'hCAFE_F00D);
        // No ack: abort
        run_op(32'h108, 32'h0, 1, 1, 0, 0, 2'b00, NEVER, 32'h0);
        // Next instruction proceeds
        run_op(32'h1234_5678, 32'h0, 1, 0, 0, 0, 2'b00, 0, 32'h0);

        // Reset in the 2nd WAIT cycle
        @(negedge clk);
        in_b = mk(32'h4, 32'h300, 32'h0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0,
                  1'b0, 2'b00);
        dmem_if.ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("wait stall", stall, 1);
        reset = 1'b0;
        #1;
        chk("midrst req", dmem_if.req, 0);
        chk("midrst stall", stall, 0);
        chk("midrst out", out_b, 0);
        chk("midrst bus_err", bus_err, 0);
        exp_bus_err = 1'b0;
        @(negedge clk);
        in_b  = mk(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 2'b00);
        reset = 1'b1;
        run_op(32'h300, 32'h0, 1, 1, 0, 0, 2'b00, 0, 32'h0BAD_F00D);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 2);
            a    = $urandom();
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            dsz  = 2'($urandom());
            lat  = $urandom_range(0, 4);
            if ($urandom_range(0, 19) == 0) lat = NEVER;
            if ($urandom_range(0, 19) == 0) lat = TIMEOUT - 1;
            unique case (kind)
                0: run_op(a, $urandom(), 1'($urandom()), 0, 0,
                          1'($urandom()), dsz, lat, $urandom());
                1: run_op(a, $urandom(), 1, 1, 0, 1'($urandom()),
                          dsz, lat, $urandom());
                default: run_op(a, $urandom(), 0, 0, 1,
                                1'($urandom()), dsz, lat, $urandom());
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline; consumes the EX/MEM bundle and drives the data-memory port.
- Handles big-endian byte/halfword/word loads and stores, stalls upstream while memory is busy, and aborts on timeout.
- Contains the MEM/WB pipeline register; its output feeds writeback.

Parameters:
- IN_W, 174, EX/MEM bundle width.
- OUT_W, 104, MEM/WB bundle width.
- TIMEOUT, 16, maximum cycles waiting for dmem_ack before abort (≥2).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset; one clock, no other reset.
- in  in  [0:173]  EX/MEM bundle: nextPC[0:31], opB[32:63], destReg[64:68], aluResult[69:100], PCtoReg[101], RegToPC[102], RegWrite[103], MemToReg[104], MemWrite[105], loadSign[106], DSize[107:108], leapAddr[109:140], leap[141], memVal[142:173]. leap/leapAddr/RegToPC are ignored.
- out  out  [0:103]  MEM/WB bundle: nextPC[0:31], destReg[32:36], aluResult[37:68], loadData[69:100], PCtoReg[101], RegWrite[102], MemToReg[103].
- stall  out  1  freeze PC/IF/ID/EX and EX/MEM register (holds `in` stable).
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  [0:31]  word-aligned address {aluResult[0:29],2'b00}.
- dmem_wdata  out  [0:31]  store data, lane-replicated.
- dmem_be  out  [0:3]  byte enables; be[k] = byte at address offset k, bits [8k:8k+7].
- dmem_rdata  in  [0:31]  read data, valid when dmem_ack=1.
- dmem_ack  in  1  access complete; may arrive in the request cycle.
- misalign  out  1  one-cycle pulse: misaligned access dropped.
- bus_err  out  1  sticky: timeout occurred; cleared only by reset.

Behaviour:
- memop = MemToReg | MemWrite. Bubbles arrive with RegWrite = MemToReg = MemWrite = 0.
- DSize encoding:
  - 00 = word; 01 = halfword; 10 = byte; 11 = word.
  - Misaligned means word with addr[30:31]≠0, or halfword with addr[31]=1.
- FSM states IDLE, WAIT.
  - IDLE, memop and aligned: dmem_req=1 combinationally. If dmem_ack, complete with no stall. Else stall=1 and go to WAIT next edge, counter cleared.
  - WAIT: dmem_req=1 with held address, data and byte enables. Counter increments each cycle.
    - dmem_ack: complete, stall=0, go to IDLE.
    - Counter = TIMEOUT-1 with no ack: abort. req=0, stall=0, bus_err←1, MEM/WB captures with RegWrite=0, go to IDLE.
    - Ack in the same cycle as timeout: ack wins.
- Misaligned memop: no request, misalign=1 for that cycle, no stall, MEM/WB captures with RegWrite=0, MemToReg=0.
- stall = memop & aligned & ~dmem_ack & ~abort.
- MEM/WB register:
  - Loads the next bundle on every edge where stall=0.
  - While stall=1 it loads a bubble (all zero), so writeback never sees a duplicate.
  - Latency is 1 cycle when dmem_ack arrives in the request cycle.
- Loads, by byte offset o = addr[30:31]:
  - Byte: rdata[8o:8o+7].
  - Halfword: rdata[0:15] if o=0, rdata[16:31] if o=2.
  - Word: rdata.
  - Zero-extend, or sign-extend when loadSign=1.
  - loadData = 0 for non-loads.
- Stores use memVal.
  - Byte: wdata = 4× memVal[24:31], be one-hot at o.
  - Halfword: wdata = 2× memVal[16:31], be = 1100 (o=0) or 0011 (o=2).
  - Word: wdata = memVal, be = 1111.
  - Loads drive be = 1111, we=0.
- Reset (any time, including mid-WAIT):
  - state=IDLE, counter=0, out=0, bus_err=0.
  - dmem_req, stall and misalign read 0 while reset is asserted.

Decomposition:
- Shared package holds:
  - DSize codes (DSZ_WORD/HALF/BYTE).
  - EX/MEM and MEM/WB field offsets and widths.
  - FSM state encoding.
- One sub-module, mem_align: purely combinational. Handles store lane/byte-enable generation, load extract/extend, and the misalign check. Reused by the FSM/register top.

Test Plan:
- LW at aluResult 0x100, ack in the request cycle, rdata 0xDEADBEEF → stall never 1; next cycle out.loadData=0xDEADBEEF, RegWrite=1.
- LB at 0x103 with loadSign=1, rdata 0x000000F0, ack after 3 cycles → stall high for 3 cycles with the bubble written each stalled cycle; then loadData=0xFFFFFFF0. Same with loadSign=0 → 0x000000F0.
- SH at 0x202 with memVal 0x1234ABCD → dmem_addr=0x200, we=1, wdata=0xABCDABCD, be=0011.
- LW at 0x101 → misalign pulse, dmem_req=0, out.RegWrite=0, no stall.
- No ack with TIMEOUT=16 → stall for exactly 15 cycles, abort on the 16th request cycle, bus_err=1 persists, next instruction proceeds. A second variant asserts ack exactly in the timeout cycle → normal completion, bus_err stays 0.
- reset asserted in the 2nd WAIT cycle → dmem_req, stall and out are 0 immediately. After release, a fresh LW completes normally.
